shift_sequencer: RTL and testbench



---
 rtl/shift_seq_pkg.sv | 17 +
 rtl/shift_sequencer_shifts.sv | 22 ++
 rtl/shift_sequencer.sv | 86 ++++++++
 tb/tb_shift_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
// Imported by the controller and its single-pass shifter.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Largest distance the 3-bit shifter field can encode
  localparam int MAX_STEP = 7;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_shifts.sv
// Single-pass combinational shifter, up to 7 positions per use.
// direccion: 0 = sll, 1 = srl, 2 = sra, others pass through.
module shifts #(
  parameter int n = 15
) (
  input  logic [n-1:0] data,
  input  logic [2:0]   shift,
  input  logic [2:0]   direccion,
  output logic [n-1:0] shifted
);

  always_comb begin
    shifted = data;
    case (direccion)
      3'd0:    shifted = data << shift;
      3'd1:    shifted = data >> shift;
      3'd2:    shifted = $signed(data) >>> shift;
      default: shifted = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass controller: drives the single-pass shifter once per clock
// until the full requested distance is applied, then holds the result.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N     = 15,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [N-1:0]     data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  output logic [N-1:0]     result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic [AMT_W-1:0] pass_count
);

  state_t           state;
  logic [N-1:0]     acc;
  logic [N-1:0]     shifted;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] rem_next;
  logic [2:0]       step;
  logic             dir_q;

  // step = min(remaining, 7)
  assign step = (remaining > AMT_W'(MAX_STEP))
              ? 3'(MAX_STEP)
              : remaining[2:0];

  assign rem_next = remaining - AMT_W'(step);

  shifts #(
    .n(N)
  ) u_shifts (
    .data     (acc),
    .shift    (step),
    .direccion({2'b0, dir_q}),
    .shifted  (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      remaining  <= '0;
      pass_count <= '0;
      dir_q      <= DIR_LEFT;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            acc        <= data_in;
            remaining  <= amount;
            dir_q      <= dir;
            pass_count <= '0;
            state      <= (amount == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          acc        <= shifted;
          remaining  <= rem_next;
          pass_count <= pass_count + 1'b1;
          if (rem_next == '0)
            state <= DONE;
        end
        DONE: begin
          if (result_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign result       = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int N     = 15;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [N-1:0]     data_in;
  logic [AMT_W-1:0] amount;
  logic             dir;
  logic [N-1:0]     result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic [AMT_W-1:0] pass_count;

  int vectors = 0;
  int miscompares = 0;

  shift_sequencer #(
    .N    (N),
    .AMT_W(AMT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .data_in     (data_in),
    .amount      (amount),
    .dir         (dir),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy),
    .pass_count  (pass_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".start_ready"}, 32'(start_ready), 32'd1);
    chk({tag, ".result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic accept(input logic [N-1:0] d,
                        input logic [AMT_W-1:0] a,
                        input logic dr);
    data_in     = d;
    amount      = a;
    dir         = dr;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    data_in     = '0;
    amount      = '0;
    dir         = DIR_LEFT;
  endtask

  // Latency counts edges from the accept edge (accept edge = 1).
  task automatic expect_done(input string tag,
                             input int lat,
                             input logic [N-1:0] res,
                             input logic [AMT_W-1:0] pc);
    int n = 1;
    while (!result_valid && n < 16) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".result"}, 32'(result), 32'(res));
    chk({tag, ".pass_count"}, 32'(pass_count), 32'(pc));
  endtask

  task automatic drain(input string tag);
    result_ready = 1'b1;
    tick();
    chk_idle({tag, ".after_hs"});
  endtask

  initial begin
    rst          = 1'b1;
    start_valid  = 1'b0;
    data_in      = '0;
    amount       = '0;
    dir          = DIR_LEFT;
    result_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.pass_count", 32'(pass_count), 32'd0);

    accept(15'h0001, 4'd10, DIR_LEFT);
    chk("l10.busy", 32'(busy), 32'd1);
    chk("l10.start_ready", 32'(start_ready), 32'd0);
    expect_done("l10", 3, 15'h0400, 4'd2);
    drain("l10");

    accept(15'h4000, 4'd9, DIR_RIGHT);
    expect_done("r9", 3, 15'h0020, 4'd2);
    drain("r9");

    accept(15'h1234, 4'd0, DIR_LEFT);
    expect_done("a0", 1, 15'h1234, 4'd0);
    drain("a0");

    accept(15'h7FFF, 4'd15, DIR_LEFT);
    expect_done("l15", 4, 15'h0000, 4'd3);
    drain("l15");

    accept(15'h0001, 4'd14, DIR_LEFT);
    expect_done("l14", 3, 15'h4000, 4'd2);
    drain("l14");

    // Backpressure with a competing request held on start_valid
    result_ready = 1'b0;
    accept(15'h0003, 4'd4, DIR_LEFT);
    expect_done("bp", 2, 15'h0030, 4'd1);
    data_in     = 15'h0100;
    amount      = 4'd8;
    dir         = DIR_RIGHT;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.hold_result", 32'(result), 32'h0030);
      chk("bp.hold_valid", 32'(result_valid), 32'd1);
      chk("bp.start_ready", 32'(start_ready), 32'd0);
    end
    result_ready = 1'b1;
    tick();
    chk_idle("bp.after_hs");
    chk("bp.pc_kept", 32'(pass_count), 32'd1);
    accept(15'h0100, 4'd8, DIR_RIGHT);
    expect_done("bp2", 3, 15'h0001, 4'd2);
    drain("bp2");

    // Reset during the second RUN cycle of a 15-position request
    accept(15'h7FFF, 4'd15, DIR_LEFT);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midrst");
    chk("midrst.result", 32'(result), 32'd0);
    chk("midrst.pass_count", 32'(pass_count), 32'd0);
    tick();
    tick();
    chk("midrst.no_result", 32'(result_valid), 32'd0);

    accept(15'h7FFF, 4'd3, DIR_RIGHT);
    expect_done("post_rst", 2, 15'h0FFF, 4'd1);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end, want completion");
    $fatal(1, "timeout");
  end

endmodule
